// File: rtl/ariscv_grf_mp_pkg.sv
// ariscv GRF shared defaults and FSM state type.
// Imported by the GRF interface, read port and top.
package ariscv_pkg;

  localparam int XLEN_D = 32;
  localparam int AW_D   = 5;

  localparam logic [XLEN_D-1:0] RSTVAL_D = '0;

  typedef enum logic [1:0] {
    IDLE,
    SCRUB,
    DACK
  } grf_state_t;

endpackage

// File: rtl/ariscv_grf_mp_if.sv
// Debug req/ack port of the multi-port GRF.
// master: dbg_req/we/addr/wdata out; slave: dbg_ack/rdata out.
interface ariscv_grf_mp_if
  import ariscv_pkg::*;
#(
  parameter int AW   = AW_D,
  parameter int XLEN = XLEN_D
);

  logic            dbg_req;
  logic            dbg_we;
  logic [AW-1:0]   dbg_addr;
  logic [XLEN-1:0] dbg_wdata;
  logic            dbg_ack;
  logic [XLEN-1:0] dbg_rdata;

  modport master (
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata
  );

  modport slave (
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata
  );

endinterface

// File: rtl/ariscv_grf_rdport.sv
// One combinational GRF read port: x0/out-of-range zero,
// scrub mask, write->read bypass. Ports: mem, a, busy, byp, wa, wd -> d.
module ariscv_grf_rdport
  import ariscv_pkg::*;
#(
  parameter int              NREG   = 32,
  parameter int              AW     = AW_D,
  parameter int              XLEN   = XLEN_D,
  parameter int              BYPASS = 1,
  parameter logic [XLEN-1:0] RSTVAL = '0
) (
  input  logic [XLEN-1:0] mem [NREG],
  input  logic [AW-1:0]   a,
  input  logic            busy,
  input  logic            byp,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] d
);

  localparam int IW = $clog2(NREG);

  logic ok;

  always_comb begin
    ok = (a != '0) && (int'(a) < NREG);
    d  = '0;
    if (ok) begin
      if (busy)
        d = RSTVAL;
      else if ((BYPASS != 0) && byp && (wa == a))
        d = wd;
      else
        d = mem[a[IW-1:0]];
    end
  end

endmodule

// File: rtl/ariscv_grf_mp.sv
// Multi-read-port GRF, x0 = 0, srst scrub, arbitrated debug port.
// Ports: clk arst_n srst, rd_a/rd_d, we/wa/wd/wr_stall, busy, dbg.
module ariscv_grf_mp
  import ariscv_pkg::*;
#(
  parameter int              NREG   = 32,
  parameter int              AW     = AW_D,
  parameter int              XLEN   = XLEN_D,
  parameter int              NRD    = 2,
  parameter int              BYPASS = 1,
  parameter logic [XLEN-1:0] RSTVAL = RSTVAL_D,
  parameter int              STARVE = 4
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              srst,
  input  logic [NRD*AW-1:0] rd_a,
  output logic [NRD*XLEN-1:0] rd_d,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [XLEN-1:0]   wd,
  output logic              wr_stall,
  output logic              busy,
  ariscv_grf_mp_if.slave    dbg
);

  localparam int IW = $clog2(NREG);
  localparam int SW = $clog2(STARVE + 1);

  localparam logic [SW-1:0] SMAX = SW'(STARVE);
  localparam logic [AW-1:0] PEND = AW'(NREG - 1);
  localparam logic [AW-1:0] PONE = AW'(1);

  grf_state_t      st;
  logic [XLEN-1:0] mem [NREG];
  logic [AW-1:0]   ptr;
  logic [SW-1:0]   starve;
  logic [XLEN-1:0] rdata;

  logic idle;
  logic go;
  logic cwr;
  logic wok;
  logic dok;

  // go: debug access happens at this edge.
  always_comb begin
    idle     = (st == IDLE);
    busy     = (st == SCRUB);
    go       = idle & ~srst & dbg.dbg_req &
               (~we | (starve >= SMAX));
    wr_stall = we & (busy | go);
    cwr      = we & ~wr_stall;
    wok      = (wa != '0) && (int'(wa) < NREG);
    dok      = (dbg.dbg_addr != '0) &&
               (int'(dbg.dbg_addr) < NREG);
  end

  assign dbg.dbg_ack   = (st == DACK);
  assign dbg.dbg_rdata = rdata;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < NREG; i++)
        mem[i] <= RSTVAL;
    end else if (busy) begin
      mem[ptr[IW-1:0]] <= RSTVAL;
    end else if (go & dbg.dbg_we & dok) begin
      mem[dbg.dbg_addr[IW-1:0]] <= dbg.dbg_wdata;
    end else if (cwr & wok) begin
      mem[wa[IW-1:0]] <= wd;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      st     <= IDLE;
      ptr    <= PONE;
      starve <= '0;
      rdata  <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          if (srst) begin
            st  <= SCRUB;
            ptr <= PONE;
          end else if (go) begin
            st <= DACK;
            if (!dbg.dbg_we)
              rdata <= dok ? mem[dbg.dbg_addr[IW-1:0]]
                           : '0;
          end else if (dbg.dbg_req & we &
                       (starve < SMAX)) begin
            starve <= starve + 1'b1;
          end
        end
        SCRUB: begin
          if (srst) begin
            ptr <= PONE;
          end else if (ptr == PEND) begin
            st  <= IDLE;
            ptr <= PONE;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        DACK: begin
          starve <= '0;
          ptr    <= PONE;
          st     <= srst ? SCRUB : IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    ariscv_grf_rdport #(
      .NREG   (NREG),
      .AW     (AW),
      .XLEN   (XLEN),
      .BYPASS (BYPASS),
      .RSTVAL (RSTVAL)
    ) u_rd (
      .mem  (mem),
      .a    (rd_a[k*AW +: AW]),
      .busy (busy),
      .byp  (cwr),
      .wa   (wa),
      .wd   (wd),
      .d    (rd_d[k*XLEN +: XLEN])
    );
  end

endmodule
